// File: rtl/noise_rx_checker.sv
// Recovers bits from a noisy square-wave return by majority vote per bit period,
// locks onto the alternating pattern and counts pattern errors while locked.
`timescale 1ns/1ps
module noise_rx_checker #(
   parameter int unsigned DIV    = 250,
   parameter int unsigned LOCK_N = 16,
   parameter int unsigned LOSS_N = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        clear,
   input  logic        rx_in,
   output logic        bit_out,
   output logic        bit_valid,
   output logic        locked,
   output logic [9:0]  err_count,
   output logic [15:0] bit_count
);

   localparam int unsigned PW = $clog2(DIV);
   localparam int unsigned AW = $clog2(DIV + 1);
   localparam int unsigned NW = 8;
   localparam int unsigned EW = 10;
   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

   state_t          state_q, state_d;
   logic            rx_meta, rx_s, rx_prev;
   logic [PW-1:0]   phase_q, phase_d;
   logic [AW-1:0]   acc_q, acc_d, total;
   logic [NW-1:0]   tog_q, tog_d, miss_q, miss_d;
   logic            exp_q, exp_d;
   logic            bit_d, bit_dec, edge_hit, mismatch, decide;
   logic [EW-1:0]   err_d;
   logic [CW-1:0]   cnt_d;

   assign bit_valid = decide;
   assign locked    = (state_q == LOCKED);

   // Next-state, bit decision and counter updates
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      acc_d    = acc_q;
      tog_d    = tog_q;
      miss_d   = miss_q;
      exp_d    = exp_q;
      bit_d    = bit_out;
      err_d    = err_count;
      cnt_d    = bit_count;
      decide   = 1'b0;
      total    = acc_q + AW'(rx_s);
      bit_dec  = (total > AW'(DIV / 2));
      edge_hit = rx_s ^ rx_prev;
      mismatch = (bit_dec != exp_q);

      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = HUNT;
               phase_d = '0;
               acc_d   = '0;
               tog_d   = '0;
               miss_d  = '0;
            end
            HUNT, LOCKED: begin
               // The transition cycle itself becomes phase 0 of the new bit
               if (state_q == HUNT && edge_hit) begin
                  phase_d = PW'(1);
                  acc_d   = AW'(rx_s);
               end else if (phase_q == PW'(DIV - 1)) begin
                  decide  = 1'b1;
                  phase_d = '0;
                  acc_d   = '0;
                  bit_d   = bit_dec;
                  if (state_q == HUNT) begin
                     if (bit_dec != bit_out) begin
                        tog_d = tog_q + NW'(1);
                        if (tog_d == NW'(LOCK_N)) begin
                           state_d = LOCKED;
                           exp_d   = ~bit_dec;
                           tog_d   = '0;
                           miss_d  = '0;
                        end
                     end else begin
                        tog_d = '0;
                     end
                  end else begin
                     exp_d = ~exp_q;
                     if (bit_count != '1) cnt_d = bit_count + CW'(1);
                     if (mismatch) begin
                        if (err_count != '1) err_d = err_count + EW'(1);
                        miss_d = miss_q + NW'(1);
                        if (miss_d == NW'(LOSS_N)) begin
                           state_d = HUNT;
                           miss_d  = '0;
                           tog_d   = '0;
                        end
                     end else begin
                        miss_d = '0;
                     end
                  end
               end else begin
                  phase_d = phase_q + PW'(1);
                  acc_d   = total;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (clear) begin
         err_d = '0;
         cnt_d = '0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rx_meta   <= 1'b0;
         rx_s      <= 1'b0;
         rx_prev   <= 1'b0;
         phase_q   <= '0;
         acc_q     <= '0;
         tog_q     <= '0;
         miss_q    <= '0;
         exp_q     <= 1'b0;
         bit_out   <= 1'b0;
         err_count <= '0;
         bit_count <= '0;
      end else begin
         state_q   <= state_d;
         rx_meta   <= rx_in;
         rx_s      <= rx_meta;
         rx_prev   <= rx_s;
         phase_q   <= phase_d;
         acc_q     <= acc_d;
         tog_q     <= tog_d;
         miss_q    <= miss_d;
         exp_q     <= exp_d;
         bit_out   <= bit_d;
         err_count <= err_d;
         bit_count <= cnt_d;
      end
   end

endmodule

// File: tb/tb_noise_rx_checker.sv
// Bench for noise_rx_checker: directed bit streams, decided bits checked through
// per-instance scoreboards, lock/count state checked at bit-boundary checkpoints.
`timescale 1ns/1ps
module tb_noise_rx_checker;

   localparam int unsigned DIV_A = 16;
   localparam int unsigned DIV_B = 8;

   logic clk = 1'b0;
   logic reset_n, enable_a, enable_b, clear, rx_a, rx_b;
   logic bit_out_a, bit_valid_a, locked_a, bit_out_b, bit_valid_b, locked_b;
   logic [9:0]  err_a, err_b;
   logic [15:0] cnt_a, cnt_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit q_a[$];
   bit q_b[$];
   bit mon_a = 0, mon_b = 0, pend_a = 0, pend_b = 0, watch_bv = 0;
   bit w_a, w_b;
   int bv_seen = 0;

   noise_rx_checker #(.DIV(DIV_A), .LOCK_N(4), .LOSS_N(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .enable(enable_a), .clear(clear), .rx_in(rx_a),
      .bit_out(bit_out_a), .bit_valid(bit_valid_a), .locked(locked_a),
      .err_count(err_a), .bit_count(cnt_a));

   noise_rx_checker #(.DIV(DIV_B), .LOCK_N(4), .LOSS_N(255)) dut_b (
      .clk(clk), .reset_n(reset_n), .enable(enable_b), .clear(clear), .rx_in(rx_b),
      .bit_out(bit_out_b), .bit_valid(bit_valid_b), .locked(locked_b),
      .err_count(err_b), .bit_count(cnt_b));

   always #5 clk = ~clk;

   task automatic check(input string name, input longint got, input longint want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic chk_a(input string tag, input int lk, input int er, input int ct);
      check({tag, "_locked"}, locked_a, lk);
      check({tag, "_err"}, err_a, er);
      check({tag, "_cnt"}, cnt_a, ct);
   endtask

   task automatic chk_b(input string tag, input int lk, input int er, input int ct);
      check({tag, "_locked"}, locked_b, lk);
      check({tag, "_err"}, err_b, er);
      check({tag, "_cnt"}, cnt_b, ct);
   endtask

   task automatic chk_zero_a(input string tag);
      check({tag, "_bit_out"}, bit_out_a, 0);
      check({tag, "_bit_valid"}, bit_valid_a, 0);
      chk_a(tag, 0, 0, 0);
   endtask

   // One bit period on dut_a; optionally pulses clear in cycle clr_at of the period
   task automatic send_a(input bit b, input int clr_at = -1);
      rx_a = b;
      q_a.push_back(b);
      for (int i = 0; i < int'(DIV_A); i++) begin
         clear = (i == clr_at);
         if (i == clr_at) check("clear_with_valid", bit_valid_a, 1);
         @(posedge clk); #1;
      end
      clear = 1'b0;
   endtask

   task automatic send_b(input bit b);
      rx_b = b;
      q_b.push_back(b);
      repeat (DIV_B) begin
         @(posedge clk); #1;
      end
   endtask

   // Scoreboard monitors: bit_out is compared the cycle after bit_valid
   always @(negedge clk) begin
      if (pend_a) begin
         pend_a = 0;
         if (q_a.size() == 0) check("sb_a_extra_valid", 1, 0);
         else begin
            w_a = q_a.pop_front();
            check("sb_a_bit", bit_out_a, w_a);
         end
      end
      if (mon_a && bit_valid_a) pend_a = 1;
      if (watch_bv && bit_valid_a) bv_seen++;
   end

   always @(negedge clk) begin
      if (pend_b) begin
         pend_b = 0;
         if (q_b.size() == 0) check("sb_b_extra_valid", 1, 0);
         else begin
            w_b = q_b.pop_front();
            check("sb_b_bit", bit_out_b, w_b);
         end
      end
      if (mon_b && bit_valid_b) pend_b = 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; enable_a = 0; enable_b = 0; clear = 0; rx_a = 0; rx_b = 0;
      #12;
      chk_zero_a("reset");
      chk_b("reset_b", 0, 0, 0);
      @(posedge clk); #1 reset_n = 1;
      repeat (2) @(posedge clk);
      #1;
      chk_zero_a("idle");

      // Acquire lock on a clean alternating stream (b0..b4)
      mon_a = 1; enable_a = 1;
      send_a(1); send_a(0); send_a(1); send_a(0);
      chk_a("hunt3", 0, 0, 0);
      send_a(1);
      chk_a("lock", 1, 0, 0);

      // b5..b10 clean
      for (int n = 5; n <= 10; n++) send_a(bit'(n % 2 == 0));
      chk_a("clean", 1, 0, 6);

      // b11..b20 held at 1: odd bits mismatch, isolated
      repeat (10) send_a(1);
      chk_a("isolated", 1, 5, 16);

      // b21..b25 phase inverted: 4th consecutive miss drops lock
      send_a(1); send_a(0); send_a(1); send_a(0);
      chk_a("inv3", 1, 8, 20);
      send_a(1);
      chk_a("loss", 0, 9, 21);

      // b26..b28 relock, b29 mismatch
      send_a(0); send_a(1); send_a(0); send_a(0);
      chk_a("relock", 1, 9, 21);
      send_a(0, 1);
      chk_a("clear", 1, 0, 0);
      send_a(1);
      chk_a("post_clear", 1, 0, 1);

      // Disable: counts hold, bit_valid stays low, state IDLE
      mon_a = 0; pend_a = 0; q_a.delete();
      enable_a = 0; rx_a = 0; watch_bv = 1;
      repeat (40) @(posedge clk);
      #1 watch_bv = 0;
      check("disabled_valid", bv_seen, 0);
      chk_a("disabled", 0, 0, 1);

      mon_a = 1; enable_a = 1;
      send_a(1); send_a(0); send_a(1); send_a(0); send_a(1);
      chk_a("relock_en", 1, 0, 1);
      send_a(0); send_a(1); send_a(0);
      chk_a("run_en", 1, 0, 4);

      // Asynchronous reset mid-lock
      #2 reset_n = 0;
      #1;
      chk_zero_a("async_rst");
      mon_a = 0; pend_a = 0; q_a.delete();
      enable_a = 0; rx_a = 0;
      repeat (3) @(posedge clk);
      #4 reset_n = 1;
      @(posedge clk); #1;
      chk_zero_a("after_rst");
      mon_a = 1; enable_a = 1;
      send_a(1); send_a(0); send_a(1); send_a(0); send_a(1);
      chk_a("relock_rst", 1, 0, 0);
      mon_a = 0; pend_a = 0; q_a.delete(); enable_a = 0;

      // Error saturation: lock, slip phase by one bit, 255 misses, repeat
      mon_b = 1; enable_b = 1;
      for (int r = 0; r < 5; r++) begin
         send_b(1);
         if (r > 0) chk_b("round", 0, (255 * r > 1023) ? 1023 : 255 * r, 255 * r);
         send_b(0); send_b(1); send_b(0);
         for (int j = 0; j < 255; j++) begin
            send_b(bit'(j % 2));
            if (r == 0 && j == 0) check("b_locked", locked_b, 1);
         end
      end
      send_b(1);
      chk_b("saturate", 0, 1023, 1275);
      mon_b = 0; enable_b = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/noise_rx_checker.md
NOISE_RX_CHECKER -- requirements
Module: noise_rx_checker

Interface
REQ-001 Parameter DIV, default 250, SHALL be the clocks per received bit (50 MHz / 200 kbit/s); legal range 8..4095.
REQ-002 Parameter LOCK_N, default 16, SHALL be the consecutive correct toggles required to declare lock; legal range 2..255.
REQ-003 Parameter LOSS_N, default 8, SHALL be the consecutive mismatched bits that drop lock; legal range 2..255.
REQ-004 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 enable  input  1  SHALL gate operation; low freezes counters and forces state IDLE.
REQ-007 clear  input  1  SHALL synchronously zero err_count and bit_count without changing lock state.
REQ-008 rx_in  input  1  SHALL be the noisy returned signal, asynchronous to clk.
REQ-009 bit_out  output  1  SHALL be the most recent decided bit.
REQ-010 bit_valid  output  1  SHALL pulse high for one clk when bit_out updates.
REQ-011 locked  output  1  SHALL be high only in state LOCKED.
REQ-012 err_count  output  10  SHALL be the count of mismatched bits while LOCKED.
REQ-013 bit_count  output  16  SHALL be the count of bits checked while LOCKED.

Function
REQ-014 rx_in SHALL pass through a two-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-015 A phase counter SHALL run 0..DIV-1 and wrap; a ones-accumulator SHALL add rx_s each clk of the bit period.
REQ-016 At phase DIV-1, the decided bit SHALL be 1 iff the accumulator exceeds DIV/2 (integer); bit_valid asserts in that cycle; bit_out updates on the following edge; accumulator restarts at the next period.
REQ-017 Latency: rx_in edge to first bit_valid reflecting it SHALL be at most DIV+2 clks.
REQ-018 States SHALL be IDLE, HUNT, LOCKED; reset and enable=0 give IDLE.
REQ-019 IDLE -> HUNT on the first clk with enable=1; phase, accumulator, and toggle/miss counters are zeroed on entry.
REQ-020 In HUNT, any rx_s transition SHALL force phase to 0 and clear the accumulator (edge alignment); no realignment occurs in LOCKED.
REQ-021 In HUNT, each decided bit differing from the previous decided bit SHALL increment a toggle counter; an equal bit SHALL zero it.
REQ-022 When the toggle counter reaches LOCK_N, the state SHALL become LOCKED, with the expected bit for the next period equal to the inverse of the last decided bit.
REQ-023 In LOCKED, each decided bit SHALL be compared with the expected bit; bit_count increments; on mismatch, err_count increments; the expected bit inverts every period regardless of match.
REQ-024 In LOCKED, the miss counter SHALL increment on each mismatch and zero on each match; at LOSS_N, the state returns to HUNT, and that final mismatch is still counted.
REQ-025 err_count SHALL saturate at 1023 and bit_count at 65535; there is no wrap-around.
REQ-026 If clear and an increment occur in the same cycle, clear wins and the count reads 0.
REQ-027 With enable=0, counts SHALL hold their values (not clear); bit_valid is held low.

Reset
REQ-028 Asserting reset_n low at any time SHALL immediately force: state IDLE, bit_out=0, bit_valid=0, locked=0, err_count=0, bit_count=0, synchronizer flops=0, and all internal counters=0.
REQ-029 After reset_n deasserts, the block SHALL resume at IDLE on the next rising clk edge; reset mid-lock discards lock and counts.

Verification
REQ-030 Clean 100 kHz square wave (DIV=250) on rx_in, enable=1 -> locked rises after 16 toggles (about 17 bit periods); err_count stays 0; bit_count increases by 1 per 250 clks.
REQ-031 Once locked, invert 5 isolated single bits -> err_count=5; locked stays 1.
REQ-032 Once locked, hold rx_in constant -> 4 of 8 bits mismatch alternately, the miss counter never reaches 8, so lock holds; then invert the phase for 8 consecutive bits -> locked drops after the 8th; err_count includes all 8.
REQ-033 Force more than 1023 errors with LOSS_N=255 and a constant-phase-inverted input -> err_count holds at 1023.
REQ-034 Assert clear in the same cycle as a counted mismatch -> err_count=0 and bit_count=0 next cycle; locked unchanged.
REQ-035 Pulse reset_n low mid-LOCKED, asynchronous to clk -> all outputs zero immediately; relock follows the REQ-030 timing.
